// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edge_pkg
//  Brief    : Shared types and constants for the edge-update sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package edge_pkg;

  localparam int EDGE_PRED_W   = 5;
  localparam int EDGE_WEIGHT_W = 32;
  localparam int DROP_CNT_W    = 16;

  // One exchange-rate edge update as presented to the arbitrage container.
  typedef struct packed {
    logic [EDGE_PRED_W-1:0]   src;
    logic [EDGE_PRED_W-1:0]   dst;
    logic [EDGE_WEIGHT_W-1:0] e;
  } edge_update_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KICK  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : edge_fifo
//  Brief    : Circular update buffer with wrap-bit pointers. When
//             EDGE_UPDATE_COALESCE_EN is defined, a push whose (src, dst)
//             matches a queued entry overwrites that entry's weight instead
//             of taking a new slot.
//  Revision : 1.0  initial release
// ============================================================================
module edge_fifo
  import edge_pkg::*;
#(
  parameter int PRED_W   = EDGE_PRED_W,
  parameter int WEIGHT_W = EDGE_WEIGHT_W,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [PRED_W-1:0]   push_src,
  input  logic [PRED_W-1:0]   push_dst,
  input  logic [WEIGHT_W-1:0] push_e,
  input  logic                pop,
  output logic [PRED_W-1:0]   head_src,
  output logic [PRED_W-1:0]   head_dst,
  output logic [WEIGHT_W-1:0] head_e,
  output logic                full,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [PRED_W-1:0]   mem_src [DEPTH];
  logic [PRED_W-1:0]   mem_dst [DEPTH];
  logic [WEIGHT_W-1:0] mem_e   [DEPTH];
  logic                do_push;
  logic                do_pop;
  logic                hit;
  logic [AW-1:0]       hit_idx;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_src = mem_src[rd_ptr[AW-1:0]];
  assign head_dst = mem_dst[rd_ptr[AW-1:0]];
  assign head_e   = mem_e[rd_ptr[AW-1:0]];

`ifdef EDGE_UPDATE_COALESCE_EN
  logic [AW:0] used;
  assign used = wr_ptr - rd_ptr;

  // Search every queued entry for a matching (src, dst); the head leaving
  // this cycle is excluded so its overwrite cannot be lost.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] offset;
      offset = AW'(i) - rd_ptr[AW-1:0];
      if (({1'b0, offset} < used) && !(do_pop && (offset == '0)) &&
          (mem_src[i] == push_src) && (mem_dst[i] == push_dst)) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif

  // Storage write: either a new slot at the tail or an in-place weight update.
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (hit) begin
        mem_e[hit_idx] <= push_e;
      end else begin
        mem_src[wr_ptr[AW-1:0]] <= push_src;
        mem_dst[wr_ptr[AW-1:0]] <= push_dst;
        mem_e[wr_ptr[AW-1:0]]   <= push_e;
      end
    end
  end

  // Pointer advance; simultaneous push and pop both take effect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push && !hit) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)          rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : edge_update_sequencer
//  Brief    : Queues edge updates and feeds them one at a time to the
//             arbitrage container: load u_*, pulse container_reset, skip one
//             stale-done cycle, then wait for container_done.
//             Optional: EDGE_UPDATE_COALESCE_EN merges same-(src,dst) updates.
//  Revision : 1.0  initial release
// ============================================================================
module edge_update_sequencer
  import edge_pkg::*;
#(
  parameter int PRED_W   = 5,
  parameter int WEIGHT_W = 32,
  parameter int N_VERT   = 16,
  parameter int DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PRED_W-1:0]     in_src,
  input  logic [PRED_W-1:0]     in_dst,
  input  logic [WEIGHT_W-1:0]   in_e,
  output logic [PRED_W-1:0]     u_src,
  output logic [PRED_W-1:0]     u_dst,
  output logic [WEIGHT_W-1:0]   u_e,
  output logic                  container_reset,
  input  logic                  container_done,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [PRED_W:0]     VERT_LIMIT = (PRED_W+1)'(N_VERT);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  seq_state_t          state;
  logic                full;
  logic                empty;
  logic                accept;
  logic                illegal;
  logic                push;
  logic                pop;
  logic [PRED_W-1:0]   head_src;
  logic [PRED_W-1:0]   head_dst;
  logic [WEIGHT_W-1:0] head_e;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_src == in_dst) ||
                    ({1'b0, in_src} >= VERT_LIMIT) ||
                    ({1'b0, in_dst} >= VERT_LIMIT);
  assign push     = accept && !illegal;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  edge_fifo #(
    .PRED_W   (PRED_W),
    .WEIGHT_W (WEIGHT_W),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_src (in_src),
    .push_dst (in_dst),
    .push_e   (in_e),
    .pop      (pop),
    .head_src (head_src),
    .head_dst (head_dst),
    .head_e   (head_e),
    .full     (full),
    .empty    (empty)
  );

  // Saturating count of handshaken updates rejected as malformed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (accept && illegal && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_ONE;
    end
  end

  // Run sequencer: pop -> kick pulse -> ignore one stale done -> wait done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      u_src           <= '0;
      u_dst           <= '0;
      u_e             <= '0;
      container_reset <= 1'b0;
    end else begin
      container_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            u_src           <= head_src;
            u_dst           <= head_dst;
            u_e             <= head_e;
            container_reset <= 1'b1;
            state           <= KICK;
          end
        end
        KICK:    state <= GUARD;
        GUARD:   state <= WAIT;
        WAIT:    if (container_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
